matmul_compute: RTL and testbench

- Consumer stage directly downstream of the A/B input memories.
- Once `matrices_loaded` is high, computes C = A×B, where A is M×K and B is K×N, both signed INW-bit.
- Uses a single multiply-accumulate (MAC) unit.
- Streams the M×N results out in row-major order on an AXI-Stream-style master port, then pulses `compute_finished` so the input stage can reload.

---
 rtl/matmul_pkg.sv | 33 +++
 rtl/matmul_compute_mac.sv | 34 +++
 rtl/matmul_compute.sv | 157 +++++++++++++++
 tb/tb_matmul_compute.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matrix-multiply datapath and its input stage.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_INW  = 12;
  localparam int unsigned DEF_M    = 7;
  localparam int unsigned DEF_N    = 9;
  localparam int unsigned DEF_MAXK = 8;

  // Result width: full product plus growth for a worst-case MAXK-term sum.
  function automatic int unsigned outw_f(input int unsigned inw, input int unsigned maxk);
    return 2 * inw + $clog2(maxk);
  endfunction

  function automatic int unsigned k_bits_f(input int unsigned maxk);
    return $clog2(maxk + 1);
  endfunction

  function automatic int unsigned a_addr_bits_f(input int unsigned m, input int unsigned maxk);
    return $clog2(m * maxk);
  endfunction

  function automatic int unsigned b_addr_bits_f(input int unsigned maxk, input int unsigned n);
    return $clog2(maxk * n);
  endfunction

endpackage

// File: rtl/matmul_compute_mac.sv
// Signed multiply-accumulate: acc += sext(a*b), with synchronous clear and enable.
module mac_unit
  import matmul_pkg::*;
#(
  parameter int unsigned INW  = DEF_INW,
  parameter int unsigned OUTW = outw_f(DEF_INW, DEF_MAXK)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic [INW-1:0]  a,
  input  logic [INW-1:0]  b,
  output logic [OUTW-1:0] acc
);

  logic signed [2*INW-1:0] prod;
  logic        [OUTW-1:0]  prod_ext;

  assign prod     = $signed(a) * $signed(b);
  assign prod_ext = {{(OUTW - 2*INW){prod[2*INW-1]}}, prod};

  // Accumulator register; clear wins over enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/matmul_compute.sv
// C = A x B with a single MAC; streams C row-major on an AXI-Stream master port.
module matmul_compute
  import matmul_pkg::*;
#(
  parameter  int unsigned INW         = DEF_INW,
  parameter  int unsigned M           = DEF_M,
  parameter  int unsigned N           = DEF_N,
  parameter  int unsigned MAXK        = DEF_MAXK,
  parameter  int unsigned OUTW        = outw_f(INW, MAXK),
  localparam int unsigned K_BITS      = k_bits_f(MAXK),
  localparam int unsigned A_ADDR_BITS = a_addr_bits_f(M, MAXK),
  localparam int unsigned B_ADDR_BITS = b_addr_bits_f(MAXK, N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   matrices_loaded,
  input  logic [K_BITS-1:0]      K,
  output logic [A_ADDR_BITS-1:0] A_read_addr,
  input  logic [INW-1:0]         A_data,
  output logic [B_ADDR_BITS-1:0] B_read_addr,
  input  logic [INW-1:0]         B_data,
  output logic                   compute_finished,
  output logic [OUTW-1:0]        AXIS_TDATA,
  output logic                   AXIS_TVALID,
  output logic                   AXIS_TLAST,
  input  logic                   AXIS_TREADY
);

  localparam int unsigned M_BITS = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned N_BITS = (N > 1) ? $clog2(N) : 1;

  state_t            state, state_nxt;
  logic [K_BITS-1:0] kr, k, k_inc;
  logic [M_BITS-1:0] m, m_nxt;
  logic [N_BITS-1:0] n, n_nxt;
  logic              n_wrap, last_c;
  logic              skip;
  logic              start, hs, acc_en, acc_clr;

  assign k_inc   = k + 1'b1;
  assign n_wrap  = (n == N_BITS'(N - 1));
  assign n_nxt   = n_wrap ? '0 : n + 1'b1;
  assign m_nxt   = n_wrap ? m + 1'b1 : m;
  assign last_c  = (m == M_BITS'(M - 1)) && n_wrap;
  assign acc_clr = start | hs;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    hs        = 1'b0;
    acc_en    = 1'b0;
    case (state)
      IDLE: begin
        if (matrices_loaded && !skip) begin
          state_nxt = ACCUM;
          start     = 1'b1;
        end
      end
      ACCUM: begin
        // Data for the address issued at k-1 arrives now.
        acc_en = (k != '0);
        if (k == kr) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (AXIS_TREADY) begin
          hs        = 1'b1;
          state_nxt = AXIS_TLAST ? DONE : ACCUM;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Counters, read addresses and registered stream/handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kr               <= '0;
      k                <= '0;
      m                <= '0;
      n                <= '0;
      A_read_addr      <= '0;
      B_read_addr      <= '0;
      AXIS_TVALID      <= 1'b0;
      AXIS_TLAST       <= 1'b0;
      compute_finished <= 1'b0;
      skip             <= 1'b0;
    end else begin
      compute_finished <= (state_nxt == DONE);
      // Give upstream one cycle to drop matrices_loaded after the pulse.
      skip             <= (state == DONE);

      if (start) begin
        kr          <= K;
        k           <= '0;
        m           <= '0;
        n           <= '0;
        A_read_addr <= '0;
        B_read_addr <= '0;
      end

      if (state == ACCUM) begin
        if (k != kr) begin
          k <= k_inc;
          // Step to the next (k) term only while issues remain.
          if (k_inc < kr) begin
            A_read_addr <= A_read_addr + 1'b1;
            B_read_addr <= B_read_addr + B_ADDR_BITS'(N);
          end
        end else begin
          AXIS_TVALID <= 1'b1;
          AXIS_TLAST  <= last_c;
        end
      end

      if (hs) begin
        AXIS_TVALID <= 1'b0;
        AXIS_TLAST  <= 1'b0;
        k           <= '0;
        m           <= m_nxt;
        n           <= n_nxt;
        A_read_addr <= A_ADDR_BITS'(m_nxt) * A_ADDR_BITS'(kr);
        B_read_addr <= B_ADDR_BITS'(n_nxt);
      end
    end
  end

  mac_unit #(
    .INW  (INW),
    .OUTW (OUTW)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (acc_clr),
    .en    (acc_en),
    .a     (A_data),
    .b     (B_data),
    .acc   (AXIS_TDATA)
  );

endmodule

// File: tb/tb_matmul_compute.sv
// Bench for matmul_compute: a 2x2 instance for hand-computed sequences and a default-size instance.
module tb_matmul_compute;
  import matmul_pkg::*;

  localparam int unsigned OW = outw_f(12, 8);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, tready, ml_s, ml_b, sel_big;
  logic [3:0] k_s, k_b;

  logic [3:0]    sa_addr, sb_addr;
  logic [11:0]   sa_data, sb_data;
  logic [OW-1:0] s_tdata;
  logic          s_tvalid, s_tlast, s_fin;

  logic [5:0]    ba_addr;
  logic [6:0]    bb_addr;
  logic [11:0]   ba_data, bb_data;
  logic [OW-1:0] b_tdata;
  logic          b_tvalid, b_tlast, b_fin;

  logic [11:0] ma_s [16];
  logic [11:0] mb_s [16];
  logic [11:0] ma_b [64];
  logic [11:0] mb_b [128];

  // Synchronous-read memory models: data one cycle after address.
  always @(posedge clk) begin
    sa_data <= ma_s[sa_addr];
    sb_data <= mb_s[sb_addr];
    ba_data <= ma_b[ba_addr];
    bb_data <= mb_b[bb_addr];
  end

  matmul_compute #(.INW(12), .M(2), .N(2), .MAXK(8)) u_small (
    .clk(clk), .reset(reset), .matrices_loaded(ml_s), .K(k_s),
    .A_read_addr(sa_addr), .A_data(sa_data), .B_read_addr(sb_addr), .B_data(sb_data),
    .compute_finished(s_fin), .AXIS_TDATA(s_tdata), .AXIS_TVALID(s_tvalid),
    .AXIS_TLAST(s_tlast), .AXIS_TREADY(tready)
  );

  matmul_compute u_dut (
    .clk(clk), .reset(reset), .matrices_loaded(ml_b), .K(k_b),
    .A_read_addr(ba_addr), .A_data(ba_data), .B_read_addr(bb_addr), .B_data(bb_data),
    .compute_finished(b_fin), .AXIS_TDATA(b_tdata), .AXIS_TVALID(b_tvalid),
    .AXIS_TLAST(b_tlast), .AXIS_TREADY(tready)
  );

  logic          c_valid, c_last, c_fin;
  logic [OW-1:0] c_data;
  always_comb begin
    c_valid = sel_big ? b_tvalid : s_tvalid;
    c_last  = sel_big ? b_tlast  : s_tlast;
    c_fin   = sel_big ? b_fin    : s_fin;
    c_data  = sel_big ? b_tdata  : s_tdata;
  end

  int n_cmp, n_bad;
  longint exp_q[$];
  longint got_d[$];
  bit     got_l[$];
  int     last_hs, fin_it, unstable;

  task automatic check(input string nm, input longint got, input longint exp_v);
    n_cmp++;
    if (got != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp_v);
    end
  endtask

  // Start a run on the selected DUT and record every handshaked beat until compute_finished.
  task automatic collect(input int budget, input bit rnd, input int stall_last, input bit keep_ml);
    int     stall_n = 0;
    bit     prev_v = 1'b0, prev_hs = 1'b0, prev_l = 1'b0, hs;
    longint prev_d = 0;
    got_d.delete(); got_l.delete();
    last_hs = -1; fin_it = -1; unstable = 0;
    tready = 1'b1;
    repeat (3) @(negedge clk);
    if (sel_big) ml_b = 1'b1; else ml_s = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (c_valid && c_last && stall_n < stall_last) begin
        tready = 1'b0;
        stall_n++;
      end else if (rnd) begin
        tready = 1'($urandom_range(0, 1));
      end else begin
        tready = 1'b1;
      end
      if (prev_v && !prev_hs &&
          (!c_valid || longint'($signed(c_data)) != prev_d || c_last != prev_l))
        unstable++;
      hs = c_valid && tready;
      if (hs) begin
        got_d.push_back(longint'($signed(c_data)));
        got_l.push_back(c_last);
        last_hs = i;
      end
      if (c_fin) begin
        fin_it = i;
        if (!keep_ml) begin
          if (sel_big) ml_b = 1'b0; else ml_s = 1'b0;
        end
        break;
      end
      prev_v = c_valid; prev_hs = hs; prev_l = c_last;
      prev_d = longint'($signed(c_data));
    end
    tready = 1'b1;
  endtask

  task automatic verify(input string nm, input int exp_n, input int exp_last_hs);
    int bad_v = 0, bad_l = 0;
    check({nm, " beat_count"}, got_d.size(), exp_n);
    for (int i = 0; i < got_d.size(); i++) begin
      if (i >= exp_q.size() || got_d[i] != exp_q[i]) begin
        if (bad_v == 0)
          $display("FAIL %s value[%0d]: got %0d, expected %0d", nm, i, got_d[i],
                   (i < exp_q.size()) ? exp_q[i] : 0);
        bad_v++;
      end
      if (got_l[i] != (i == exp_n - 1)) bad_l++;
    end
    check({nm, " wrong_values"}, bad_v, 0);
    check({nm, " wrong_tlast"}, bad_l, 0);
    check({nm, " finished_after_last"}, fin_it, last_hs + 1);
    check({nm, " stall_stability"}, unstable, 0);
    if (exp_last_hs > 0) check({nm, " last_handshake_cycle"}, last_hs, exp_last_hs);
  endtask

  task automatic fill_big(input int av, input int bv, input bit ramp);
    for (int i = 0; i < 64; i++)  ma_b[i] = ramp ? 12'((i % 5) - 2) : 12'(av);
    for (int i = 0; i < 128; i++) mb_b[i] = ramp ? 12'((i % 7) - 3) : 12'(bv);
  endtask

  task automatic model_big(input int kk);
    longint s;
    exp_q.delete();
    for (int mi = 0; mi < 7; mi++)
      for (int ni = 0; ni < 9; ni++) begin
        s = 0;
        for (int j = 0; j < kk; j++)
          s += longint'($signed(ma_b[mi*kk + j])) * longint'($signed(mb_b[j*9 + ni]));
        exp_q.push_back(s);
      end
  endtask

  typedef struct {
    int     k;
    int     av;
    int     bv;
    bit     ramp;
    longint first;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int hs_cnt, tv_cnt;
    vecs[0] = '{8, -2048, -2048, 1'b0, 64'sd33554432};
    vecs[1] = '{8, -2048,  2047, 1'b0, -64'sd33538048};
    vecs[2] = '{0,     7,     9, 1'b0, 64'sd0};
    vecs[3] = '{3,     0,     0, 1'b1, 64'sd7};
    vecs[4] = '{1,  2047, -2048, 1'b0, -64'sd4192256};
    vecs[5] = '{8,     0,     0, 1'b1, 64'sd4};

    n_cmp = 0; n_bad = 0;
    reset = 1'b0; tready = 1'b1; ml_s = 1'b0; ml_b = 1'b0; sel_big = 1'b0;
    k_s = 4'd2; k_b = 4'd0;
    for (int i = 0; i < 16; i++) begin ma_s[i] = 12'd0; mb_s[i] = 12'd0; end
    ma_s[0] = 12'd1; ma_s[1] = 12'd2; ma_s[2] = 12'd3; ma_s[3] = 12'd4;
    mb_s[0] = 12'd5; mb_s[1] = 12'd6; mb_s[2] = 12'd7; mb_s[3] = 12'd8;
    fill_big(0, 0, 1'b0);

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    check("rst small tvalid", s_tvalid, 0);
    check("rst small tlast", s_tlast, 0);
    check("rst small tdata", s_tdata, 0);
    check("rst small finished", s_fin, 0);
    check("rst small a_addr", sa_addr, 0);
    check("rst small b_addr", sb_addr, 0);
    check("rst big tvalid", b_tvalid, 0);
    check("rst big tlast", b_tlast, 0);
    check("rst big tdata", b_tdata, 0);
    check("rst big finished", b_fin, 0);
    @(negedge clk);
    reset = 1'b1;

    // 2x2 basic run with TREADY held high.
    exp_q = '{64'sd19, 64'sd22, 64'sd43, 64'sd50};
    collect(60, 1'b0, 0, 1'b0);
    verify("basic", 4, 16);

    // Random backpressure, TLAST element stalled for 5 cycles.
    collect(400, 1'b1, 5, 1'b0);
    verify("stall", 4, 0);

    // Asynchronous reset in the drain cycle of element 3.
    repeat (3) @(negedge clk);
    ml_s = 1'b1;
    hs_cnt = 0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (s_tvalid && tready) hs_cnt++;
    end
    check("pre_reset handshakes", hs_cnt, 2);
    check("pre_reset a_addr", sa_addr, 3);
    check("pre_reset b_addr", sb_addr, 2);
    check("pre_reset acc", s_tdata, 15);
    reset = 1'b0;
    ml_s = 1'b0;
    #1;
    check("midrst a_addr", sa_addr, 0);
    check("midrst b_addr", sb_addr, 0);
    check("midrst tdata", s_tdata, 0);
    check("midrst tvalid", s_tvalid, 0);
    @(negedge clk);
    reset = 1'b1;
    collect(60, 1'b0, 0, 1'b0);
    verify("after_reset", 4, 16);

    // Default-size instance, table of fills.
    sel_big = 1'b1;
    for (int v = 0; v < 6; v++) begin
      fill_big(vecs[v].av, vecs[v].bv, vecs[v].ramp);
      k_b = 4'(vecs[v].k);
      model_big(vecs[v].k);
      collect(63 * (vecs[v].k + 2) + 40, 1'b0, 0, 1'b0);
      verify($sformatf("vec%0d", v), 63, 63 * (vecs[v].k + 2));
      check($sformatf("vec%0d first", v), (got_d.size() > 0) ? got_d[0] : -64'sd999999,
            vecs[v].first);
    end

    // matrices_loaded held through DONE, dropped one cycle after the pulse.
    fill_big(0, 0, 1'b1);
    k_b = 4'd1;
    model_big(1);
    collect(63 * 3 + 40, 1'b0, 0, 1'b1);
    verify("hold_ml", 63, 63 * 3);
    @(negedge clk);
    ml_b = 1'b0;
    tv_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (b_tvalid) tv_cnt++;
    end
    check("hold_ml no_restart", tv_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
